// File: rtl/wam_scr_if.sv
// Whack-a-mole score keeper bus: game inputs in, score/hardness/strobes out.
interface wam_scr_if;
    logic [7:0]  holes;
    logic [7:0]  tap;
    logic        lft;
    logic        rgt;
    logic        start;
    logic [11:0] score;
    logic [3:0]  hrdn;
    logic [7:0]  whack;
    logic        cout0;
    logic        run;

    modport master (
        output holes, tap, lft, rgt, start,
        input  score, hrdn, whack, cout0, run
    );

    modport slave (
        input  holes, tap, lft, rgt, start,
        output score, hrdn, whack, cout0, run
    );
endinterface

// File: rtl/wam_scr.sv
// Whack-a-mole score and hardness keeper: round FSM, saturating BCD score,
// hardness level, per-hole whack pulses and tens-digit change strobe.
module wam_scr #(
    parameter int GAME_TICKS = 5760,
    parameter int HRDN_MAX   = 9
) (
    input  logic       clk_19,
    input  logic       rst,
    wam_scr_if.slave   bus
);
    localparam int TW = (GAME_TICKS > 1) ? $clog2(GAME_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer;
    logic [9:0]     pts;        // binary mirror of the BCD score
    logic [11:0]    score_q;
    logic [3:0]     hrdn_q;
    logic [7:0]     whack_q;
    logic           cout0_q;
    logic           run_q;

    logic [7:0]         hit, miss;
    logic [3:0]         hit_n, miss_n;
    logic signed [11:0] sum;
    logic [9:0]         pts_nxt, rem;
    logic [3:0]         d_h, d_t, d_o;

    // state register; run is decoded from the next state so it stays registered
    always_ff @(posedge clk_19 or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= (state_nxt == PLAY);
        end
    end

    // round sequencing
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)       state_nxt = PLAY;
            PLAY:    if (timer == '0)     state_nxt = OVER;
            OVER:    if (bus.start)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // hit/miss counts and the saturated next score, in binary then BCD
    always_comb begin
        hit    = bus.tap & bus.holes;
        miss   = bus.tap & ~bus.holes;
        hit_n  = '0;
        miss_n = '0;
        for (int i = 0; i < 8; i++) begin
            hit_n  = hit_n  + {3'b000, hit[i]};
            miss_n = miss_n + {3'b000, miss[i]};
        end
        sum = $signed({2'b00, pts}) + $signed({8'h00, hit_n}) - $signed({8'h00, miss_n});
        if (sum < 12'sd0)
            pts_nxt = 10'd0;
        else if (sum > 12'sd999)
            pts_nxt = 10'd999;
        else
            pts_nxt = sum[9:0];
        d_h = 4'(pts_nxt / 10'd100);
        rem = pts_nxt % 10'd100;
        d_t = 4'(rem / 10'd10);
        d_o = 4'(rem % 10'd10);
    end

    // score, timer and strobes; the clear at round entry never raises cout0
    always_ff @(posedge clk_19 or posedge rst) begin
        if (rst) begin
            pts     <= '0;
            score_q <= '0;
            whack_q <= '0;
            cout0_q <= 1'b0;
            timer   <= '0;
        end else begin
            whack_q <= '0;
            cout0_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    pts     <= '0;
                    score_q <= '0;
                    timer   <= TW'(GAME_TICKS - 1);
                end
                PLAY: begin
                    pts     <= pts_nxt;
                    score_q <= {d_h, d_t, d_o};
                    whack_q <= hit;
                    cout0_q <= (d_t != score_q[7:4]);
                    if (timer != '0) timer <= timer - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // hardness is only adjustable between rounds; simultaneous lft+rgt cancel
    always_ff @(posedge clk_19 or posedge rst) begin
        if (rst) begin
            hrdn_q <= 4'd1;
        end else if (state == IDLE) begin
            if (bus.rgt && !bus.lft && hrdn_q < 4'(HRDN_MAX))
                hrdn_q <= hrdn_q + 4'd1;
            else if (bus.lft && !bus.rgt && hrdn_q > 4'd1)
                hrdn_q <= hrdn_q - 4'd1;
        end
    end

    assign bus.score = score_q;
    assign bus.hrdn  = hrdn_q;
    assign bus.whack = whack_q;
    assign bus.cout0 = cout0_q;
    assign bus.run   = run_q;
endmodule

// File: tb/tb_wam_scr.sv
// Directed bench for wam_scr: hardness, scoring, BCD carry, saturation,
// round length and asynchronous reset mid-round.
module tb_wam_scr;
    localparam int GT = 200;

    logic clk_19 = 1'b0;
    logic rst    = 1'b1;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   cnt;

    wam_scr_if bus();

    wam_scr #(.GAME_TICKS(GT), .HRDN_MAX(9)) u_dut (
        .clk_19 (clk_19),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_19 = ~clk_19;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] msk(input int k);
        msk = 8'((1 << k) - 1);
    endfunction

    // drive one edge's inputs, advance past the edge, drop the pulses
    task automatic cyc(input logic [7:0] h, input logic [7:0] t,
                       input logic l, input logic r, input logic s);
        bus.holes = h;
        bus.tap   = t;
        bus.lft   = l;
        bus.rgt   = r;
        bus.start = s;
        @(posedge clk_19);
        #1;
        bus.tap   = '0;
        bus.lft   = 1'b0;
        bus.rgt   = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic add(input int k);
        if (k >= 0) cyc(8'hFF, msk(k), 1'b0, 1'b0, 1'b0);
        else        cyc(8'h00, msk(-k), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.holes = '0; bus.tap = '0; bus.lft = 1'b0; bus.rgt = 1'b0; bus.start = 1'b0;
        repeat (2) @(posedge clk_19);
        #1 rst = 1'b0;
        chk("rst_score", 32'(bus.score), 32'h000);
        chk("rst_hrdn",  32'(bus.hrdn), 32'd1);
        chk("rst_run",   32'(bus.run), 32'd0);
        chk("rst_whack", 32'(bus.whack), 32'h00);
        chk("rst_cout0", 32'(bus.cout0), 32'd0);

        // hardness in IDLE
        repeat (10) cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("hrdn_max", 32'(bus.hrdn), 32'd9);
        repeat (12) cyc(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("hrdn_min", 32'(bus.hrdn), 32'd1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("hrdn_up1", 32'(bus.hrdn), 32'd2);
        cyc(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("hrdn_both", 32'(bus.hrdn), 32'd2);

        // round A: tap on the start edge is ignored
        cyc(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b1);
        chk("a_run", 32'(bus.run), 32'd1);
        chk("a_clr", 32'(bus.score), 32'h000);
        chk("a_whk0", 32'(bus.whack), 32'h00);
        cyc(8'hA5, 8'h81, 1'b0, 1'b0, 1'b0);
        chk("hit2", 32'(bus.score), 32'h002);
        chk("hit2_whk", 32'(bus.whack), 32'h81);
        cyc(8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
        chk("miss1", 32'(bus.score), 32'h001);
        chk("miss1_whk", 32'(bus.whack), 32'h00);
        cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("hrdn_play", 32'(bus.hrdn), 32'd2);

        repeat (12) add(8);
        add(1);
        chk("s098", 32'(bus.score), 32'h098);
        chk("s098_c0", 32'(bus.cout0), 32'd0);
        add(3);
        chk("s101", 32'(bus.score), 32'h101);
        chk("s101_c0", 32'(bus.cout0), 32'd1);
        chk("s101_whk", 32'(bus.whack), 32'h07);
        add(-1);
        chk("s100", 32'(bus.score), 32'h100);
        chk("s100_c0", 32'(bus.cout0), 32'd0);
        cyc(8'h0F, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("mix", 32'(bus.score), 32'h100);
        chk("mix_whk", 32'(bus.whack), 32'h0C);

        repeat (12) add(-8);
        add(-2);
        chk("s002", 32'(bus.score), 32'h002);
        add(-7);
        chk("sat_lo", 32'(bus.score), 32'h000);
        repeat (124) add(8);
        add(6);
        chk("s998", 32'(bus.score), 32'h998);
        add(8);
        chk("sat_hi", 32'(bus.score), 32'h999);
        chk("sat_hi_c0", 32'(bus.cout0), 32'd0);
        chk("a_run2", 32'(bus.run), 32'd1);

        cnt = 0;
        while (bus.run && cnt < 100) begin
            cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            cnt++;
        end
        chk("a_end_run", 32'(bus.run), 32'd0);
        chk("a_end_cyc", 32'(cnt), 32'd41);
        chk("over_score", 32'(bus.score), 32'h999);
        cyc(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("hrdn_over", 32'(bus.hrdn), 32'd2);
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("idle_run", 32'(bus.run), 32'd0);
        chk("idle_held", 32'(bus.score), 32'h999);

        // round B: exact length, last-edge tap scored, next one ignored
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("b_clr", 32'(bus.score), 32'h000);
        chk("b_clr_c0", 32'(bus.cout0), 32'd0);
        cnt = bus.run ? 1 : 0;
        for (int i = 1; i < GT; i++) begin
            cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            if (bus.run) cnt++;
        end
        chk("b_len", 32'(cnt), 32'(GT));
        cyc(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("b_last", 32'(bus.score), 32'h001);
        chk("b_last_whk", 32'(bus.whack), 32'h01);
        chk("b_last_run", 32'(bus.run), 32'd0);
        cyc(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("b_after", 32'(bus.score), 32'h001);
        chk("b_after_whk", 32'(bus.whack), 32'h00);

        // round C: async reset mid-round
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (5) add(8);
        add(5);
        chk("c_s045", 32'(bus.score), 32'h045);
        chk("c_whk", 32'(bus.whack), 32'h1F);
        #2 rst = 1'b1;
        #1;
        chk("ar_score", 32'(bus.score), 32'h000);
        chk("ar_hrdn", 32'(bus.hrdn), 32'd1);
        chk("ar_run", 32'(bus.run), 32'd0);
        chk("ar_whk", 32'(bus.whack), 32'h00);
        #1 rst = 1'b0;
        add(4);
        add(4);
        chk("ar_tap", 32'(bus.score), 32'h000);
        chk("ar_tap_whk", 32'(bus.whack), 32'h00);
        chk("ar_tap_run", 32'(bus.run), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wam_scr.md
# wam_scr

Score and hardness keeper for the whack-a-mole game. Sits directly upstream of the digit display stage: it consumes debounced tap pulses, the live mole pattern and the hardness buttons, and produces the BCD score, the hardness digit and the carry-flash strobe the display and flash logic consume. It also runs the fixed-length game round and returns per-hole whack pulses to the mole generator so that struck moles are cleared.

## Interface
- `GAME_TICKS`, default 5760: round length in `clk_19` cycles (about 30 s at the ~190 Hz tick).
- `HRDN_MAX`, default 9: highest hardness level; the lowest level is fixed at 1.
- `clk_19` in 1: the single clock; every register is clocked on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `holes` in 8: currently lit moles, 1 = mole up.
- `tap` in 8: one-cycle debounced tap pulses, one bit per hole.
- `lft` in 1: one-cycle pulse that lowers hardness.
- `rgt` in 1: one-cycle pulse that raises hardness.
- `start` in 1: one-cycle start pulse.
- `score` out 12: three BCD digits, hundreds in [11:8], tens in [7:4], ones in [3:0].
- `hrdn` out 4: hardness, binary 1..HRDN_MAX.
- `whack` out 8: one-cycle pulse per struck hole, sent to the mole generator.
- `cout0` out 1: one-cycle pulse when the tens digit changes.
- `run` out 1: high while a round is in play.

## Operation
- States:
  - IDLE: reset state. Score is frozen. Hardness is adjustable.
  - PLAY: scoring is active and the round timer is running.
  - OVER: score and hardness are both frozen.
- Transitions:
  - IDLE→PLAY on `start`. On entry, score clears to 000 and the timer loads GAME_TICKS−1.
  - PLAY→OVER when the timer is 0 on a clock edge.
  - OVER→IDLE on `start`. The score is held until the next entry to PLAY.
  - `start` has no effect while in PLAY.
- Timer: decrements by 1 each cycle in PLAY. The round therefore lasts exactly GAME_TICKS cycles.
- Scoring, evaluated in PLAY only:
  - hit = tap & holes; miss = tap & ~holes.
  - Score update: delta = popcount(hit) − popcount(miss), range −8..+8.
  - The score is updated in BCD and saturates at 000 and 999. There is no wrap-around.
  - Worked examples: 995 + 8 → 999; 003 − 5 → 000.
- whack: equals hit, registered. It is all zero outside PLAY.
- cout0: asserted for one cycle when the tens digit of the new score differs from the old tens digit, in either direction. It does not fire on the clear at PLAY entry.
- Hardness:
  - Changes only in IDLE.
  - `rgt` alone: +1, saturating at HRDN_MAX.
  - `lft` alone: −1, saturating at 1.
  - `rgt` and `lft` together: no change.
- run = (state == PLAY).
- Reset values: state IDLE, score 000, hrdn 1, whack 0, cout0 0, run 0, timer 0.
- Reset mid-round: all of the above take effect immediately. The round is abandoned and no further whack or cout0 pulses occur.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- A tap sampled at edge k shows its effect on score, whack and cout0 immediately after edge k. Latency is 1 cycle.
- A tap on the edge that takes PLAY→OVER is still scored and whacked; that edge counts as the last PLAY cycle. Taps from the following edge onward are ignored.
- A tap on the same edge as IDLE→PLAY is ignored, because the score clears on that edge.
- `holes` and `tap` are sampled on the same edge with no skew allowance. The upstream stages guarantee alignment.
- `hrdn` updates 1 cycle after the lft/rgt pulse.
- `start` held high for several cycles: each edge is evaluated against the current state, so a held start may toggle OVER→IDLE→PLAY. Upstream delivers one-cycle pulses.

## Test plan
- Reset then hardness: after reset, hrdn=1. Apply rgt×10 → hrdn=9. Apply lft×12 → hrdn=1. Apply lft+rgt together → no change. Apply rgt during PLAY → no change.
- Basic scoring: start, then holes=8'hA5 with tap=8'h81 → 1 cycle later score=12'h002, whack=8'h81. Then tap=8'h02 with holes=0 → score=12'h001, whack=0.
- BCD carry and cout0: preload score to 12'h098 through hits, then 3 hits in one cycle → score=12'h101 and cout0 high for exactly 1 cycle. Next a single miss → score=12'h100, cout0 stays 0.
- Saturation: drive score to 12'h998, then 8 hits in one cycle → score=12'h999. Separately, at score=12'h002 apply 7 misses → score=12'h000.
- Round timing: with GAME_TICKS=16, run is high for exactly 16 cycles after start. A tap on the 16th cycle is scored; a tap on the 17th is not. start in OVER → IDLE with score held; a second start → score=12'h000.
- Async reset mid-round: assert rst between edges while in PLAY with score=12'h045 → score=0, hrdn=1, run=0 before the next edge. After release, taps do not change score.
